// File: rtl/spi_cmd_slave.sv
// SPI mode-0 command slave bridging an external master into the clk domain.
// Frame: 8-bit command then 32 data bits, MSB first. During the command byte
// miso carries the status byte; during the data phase miso carries the
// addressed register while mosi supplies write data.
// Register map: 0/1 scratch R/W, 2 read-only ID, 3 read-only frame counter.
module spi_cmd_slave #(
   parameter int          SYNC_STAGES = 2,
   parameter logic [31:0] ID_VALUE    = 32'h5350_4931
) (
   input  logic clk,
   input  logic nrst,
   input  logic sck,
   input  logic mosi,
   input  logic ncs,
   output logic miso
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_DATA = 2'd2,
      ST_OVER = 2'd3
   } state_t;

   // synchroniser chains and one-cycle delayed copies for edge detection
   logic [SYNC_STAGES-1:0] sck_sync_r;
   logic [SYNC_STAGES-1:0] mosi_sync_r;
   logic [SYNC_STAGES-1:0] ncs_sync_r;
   logic                   sck_d_r;
   logic                   ncs_d_r;

   logic sck_s;
   logic mosi_s;
   logic ncs_s;
   logic sck_rise_s;
   logic sck_fall_s;
   logic ncs_rise_s;
   logic ncs_fall_s;

   // frame state and datapath
   state_t      state_r;
   logic [5:0]  bitcnt_r;
   logic [7:0]  cmd_r;
   logic [31:0] wdata_r;
   logic [31:0] tx_r;
   logic        miso_r;
   logic        done_r;
   logic        err_r;
   logic [31:0] reg0_r;
   logic [31:0] reg1_r;
   logic [31:0] frame_cnt_r;

   logic [7:0]  status_s;
   logic [7:0]  cmd_next_s;
   logic [31:0] wdata_next_s;
   logic [31:0] rdata_s;

   assign sck_s      = sck_sync_r[SYNC_STAGES-1];
   assign mosi_s     = mosi_sync_r[SYNC_STAGES-1];
   assign ncs_s      = ncs_sync_r[SYNC_STAGES-1];
   assign sck_rise_s = sck_s & ~sck_d_r;
   assign sck_fall_s = ~sck_s & sck_d_r;
   assign ncs_rise_s = ncs_s & ~ncs_d_r;
   assign ncs_fall_s = ~ncs_s & ncs_d_r;
   assign miso       = miso_r;

   // bring sck/mosi/ncs into clk domain; reset to the idle bus levels
   always_ff @(posedge clk) begin
      if (!nrst) begin
         sck_sync_r  <= {SYNC_STAGES{1'b0}};
         mosi_sync_r <= {SYNC_STAGES{1'b0}};
         ncs_sync_r  <= {SYNC_STAGES{1'b1}};
         sck_d_r     <= 1'b0;
         ncs_d_r     <= 1'b1;
      end else begin
         sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], sck};
         mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
         ncs_sync_r  <= {ncs_sync_r[SYNC_STAGES-2:0], ncs};
         sck_d_r     <= sck_s;
         ncs_d_r     <= ncs_s;
      end
   end

   // status byte, next shift values and read mux for the address being decoded
   always_comb begin
      status_s     = {4'hA, 2'b00, err_r, done_r};
      cmd_next_s   = {cmd_r[6:0], mosi_s};
      wdata_next_s = {wdata_r[30:0], mosi_s};
      case (cmd_next_s[1:0])
         2'd0:    rdata_s = reg0_r;
         2'd1:    rdata_s = reg1_r;
         2'd2:    rdata_s = ID_VALUE;
         2'd3:    rdata_s = frame_cnt_r;
         default: rdata_s = 32'h0000_0000;
      endcase
   end

   // frame FSM: sample mosi on sck rise, advance miso on sck fall, commit on 40th rise
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_r     <= ST_IDLE;
         bitcnt_r    <= 6'd0;
         cmd_r       <= 8'h00;
         wdata_r     <= 32'h0000_0000;
         tx_r        <= 32'h0000_0000;
         miso_r      <= 1'b0;
         done_r      <= 1'b0;
         err_r       <= 1'b0;
         reg0_r      <= 32'h0000_0000;
         reg1_r      <= 32'h0000_0000;
         frame_cnt_r <= 32'h0000_0000;
      end else if (ncs_rise_s) begin
         // deselect before the commit point is an abort: nothing written
         if ((state_r == ST_CMD) || (state_r == ST_DATA)) begin
            err_r  <= 1'b1;
            done_r <= 1'b0;
         end else begin
            err_r  <= err_r;
            done_r <= done_r;
         end
         state_r  <= ST_IDLE;
         bitcnt_r <= 6'd0;
         miso_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               miso_r <= 1'b0;
               if (ncs_fall_s) begin
                  state_r <= ST_CMD;
                  miso_r  <= status_s[7];
                  tx_r    <= {status_s[6:0], 25'd0};
                  wdata_r <= 32'h0000_0000;
                  // a rise seen together with the select is bit 0
                  if (sck_rise_s) begin
                     cmd_r    <= {7'd0, mosi_s};
                     bitcnt_r <= 6'd1;
                  end else begin
                     cmd_r    <= 8'h00;
                     bitcnt_r <= 6'd0;
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_CMD: begin
               if (sck_rise_s) begin
                  cmd_r    <= cmd_next_s;
                  bitcnt_r <= bitcnt_r + 6'd1;
                  if (bitcnt_r == 6'd7) begin
                     tx_r    <= rdata_s;
                     state_r <= ST_DATA;
                  end else begin
                     state_r <= ST_CMD;
                  end
               end else if (sck_fall_s) begin
                  miso_r <= tx_r[31];
                  tx_r   <= {tx_r[30:0], 1'b0};
               end else begin
                  state_r <= ST_CMD;
               end
            end
            ST_DATA: begin
               if (sck_rise_s) begin
                  wdata_r  <= wdata_next_s;
                  bitcnt_r <= bitcnt_r + 6'd1;
                  if (bitcnt_r == 6'd39) begin
                     if (cmd_r[7]) begin
                        case (cmd_r[1:0])
                           2'd0:    reg0_r <= wdata_next_s;
                           2'd1:    reg1_r <= wdata_next_s;
                           default: reg0_r <= reg0_r;
                        endcase
                     end else begin
                        reg0_r <= reg0_r;
                     end
                     frame_cnt_r <= frame_cnt_r + 32'd1;
                     done_r      <= 1'b1;
                     err_r       <= 1'b0;
                     miso_r      <= 1'b0;
                     state_r     <= ST_OVER;
                  end else begin
                     state_r <= ST_DATA;
                  end
               end else if (sck_fall_s) begin
                  miso_r <= tx_r[31];
                  tx_r   <= {tx_r[30:0], 1'b0};
               end else begin
                  state_r <= ST_DATA;
               end
            end
            ST_OVER: begin
               miso_r  <= 1'b0;
               state_r <= ST_OVER;
            end
            default: begin
               miso_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_cmd_slave.sv
// Self-checking bench for spi_cmd_slave: a bench-side register model pushes
// expected status/read data into a scoreboard before each frame; the
// received bytes are popped and compared after the frame.
`timescale 1ns/1ps
module tb_spi_cmd_slave;

   localparam logic [31:0] ID = 32'h5350_4931;

   logic clk;
   logic nrst;
   logic sck;
   logic mosi;
   logic ncs;
   logic miso;

   int n_vec;
   int n_miss;

   typedef struct {
      logic [7:0]  st;
      logic [31:0] rd;
      bit          chk_rd;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] m_reg [0:3];
   logic        m_done;
   logic        m_err;

   spi_cmd_slave #(.SYNC_STAGES(2), .ID_VALUE(ID)) dut (
      .clk  (clk),
      .nrst (nrst),
      .sck  (sck),
      .mosi (mosi),
      .ncs  (ncs),
      .miso (miso)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // model reset state
   task automatic model_reset();
      m_reg[0] = 32'h0;
      m_reg[1] = 32'h0;
      m_reg[2] = ID;
      m_reg[3] = 32'h0;
      m_done   = 1'b0;
      m_err    = 1'b0;
   endtask

   // push the expected response for a frame, then update the model
   task automatic model_frame(input logic [7:0] cmd, input logic [31:0] wdata, input bit complete);
      exp_t e;
      e.st     = {4'hA, 2'b00, m_err, m_done};
      e.rd     = m_reg[cmd[1:0]];
      e.chk_rd = complete;
      sb_q.push_back(e);
      if (complete) begin
         if (cmd[7] && (cmd[1:0] < 2'd2)) m_reg[cmd[1:0]] = wdata;
         m_reg[3] = m_reg[3] + 32'd1;
         m_done   = 1'b1;
         m_err    = 1'b0;
      end else begin
         m_done = 1'b0;
         m_err  = 1'b1;
      end
   endtask

   // drive one SPI frame of nbits sck pulses; capture miso at each rise
   task automatic spi_frame(input logic [7:0] cmd, input logic [31:0] wdata, input int nbits,
                            input int half, output logic [7:0] st, output logic [31:0] rd,
                            output logic extra);
      logic [39:0] bits;
      bits  = {cmd, wdata};
      st    = 8'h00;
      rd    = 32'h0;
      extra = 1'b0;
      ncs   = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         mosi = (i < 40) ? bits[39-i] : 1'b0;
         #(half);
         if (i < 8) st[7-i] = miso;
         else if (i < 40) rd[39-i] = miso;
         else extra = extra | miso;
         sck = 1'b1;
         #(half);
         sck = 1'b0;
      end
      #(half);
      mosi = 1'b0;
      ncs  = 1'b1;
      #(4 * half);
   endtask

   task automatic test_reset();
      nrst = 1'b0;
      sck  = 1'b0;
      mosi = 1'b0;
      ncs  = 1'b1;
      model_reset();
      repeat (5) @(posedge clk);
      #1;
      n_vec++;
      if (miso !== 1'b0) begin
         n_miss++;
         $display("FAIL reset_miso: got %b expected 0", miso);
      end
      @(negedge clk);
      nrst = 1'b1;
      repeat (5) @(posedge clk);
   endtask

   // read reg0 after reset, then write reg0 at a slow sck and read it back
   task automatic test_read_write_reg0();
      logic [7:0]  cmds  [3];
      logic [31:0] wd    [3];
      int          halfs [3];
      logic [7:0]  st;
      logic [31:0] rd;
      logic        ex;
      exp_t        e;
      cmds = '{8'h00, 8'hA0, 8'h00};
      wd   = '{32'h1357_9BDF, 32'h24AF_55AA, 32'h0};
      halfs = '{60, 137, 60};
      for (int k = 0; k < 3; k++) begin
         model_frame(cmds[k], wd[k], 1'b1);
         spi_frame(cmds[k], wd[k], 40, halfs[k], st, rd, ex);
         e = sb_q.pop_front();
         n_vec++;
         if (st !== e.st) begin
            n_miss++;
            $display("FAIL rw0_status[%0d]: got %h expected %h", k, st, e.st);
         end
         n_vec++;
         if (rd !== e.rd) begin
            n_miss++;
            $display("FAIL rw0_rdata[%0d]: got %h expected %h", k, rd, e.rd);
         end
         @(negedge clk);
         n_vec++;
         if (miso !== 1'b0) begin
            n_miss++;
            $display("FAIL rw0_idle_miso[%0d]: got %b expected 0", k, miso);
         end
      end
   endtask

   // read-only access to reg1 with data ignored, then reg1 and ID reads
   task automatic test_reg1_and_id();
      logic [7:0]  cmds [3];
      logic [31:0] wd   [3];
      logic [7:0]  st;
      logic [31:0] rd;
      logic        ex;
      exp_t        e;
      cmds = '{8'h51, 8'h01, 8'h02};
      wd   = '{32'h0123_4567, 32'hFFFF_0000, 32'h0000_FFFF};
      for (int k = 0; k < 3; k++) begin
         model_frame(cmds[k], wd[k], 1'b1);
         spi_frame(cmds[k], wd[k], 40, 60, st, rd, ex);
         e = sb_q.pop_front();
         n_vec++;
         if (st !== e.st) begin
            n_miss++;
            $display("FAIL reg1id_status[%0d]: got %h expected %h", k, st, e.st);
         end
         n_vec++;
         if (rd !== e.rd) begin
            n_miss++;
            $display("FAIL reg1id_rdata[%0d]: got %h expected %h", k, rd, e.rd);
         end
      end
   endtask

   // deselect after 20 data bits: no write, err flag, counter unchanged
   task automatic test_abort();
      logic [7:0]  cmds [3];
      logic [31:0] wd   [3];
      int          nb   [3];
      logic [7:0]  st;
      logic [31:0] rd;
      logic        ex;
      exp_t        e;
      cmds = '{8'h80, 8'h00, 8'h03};
      wd   = '{32'hDEAD_BEEF, 32'h0, 32'h0};
      nb   = '{28, 40, 40};
      for (int k = 0; k < 3; k++) begin
         model_frame(cmds[k], wd[k], nb[k] == 40);
         spi_frame(cmds[k], wd[k], nb[k], 60, st, rd, ex);
         e = sb_q.pop_front();
         n_vec++;
         if (st !== e.st) begin
            n_miss++;
            $display("FAIL abort_status[%0d]: got %h expected %h", k, st, e.st);
         end
         if (e.chk_rd) begin
            n_vec++;
            if (rd !== e.rd) begin
               n_miss++;
               $display("FAIL abort_rdata[%0d]: got %h expected %h", k, rd, e.rd);
            end
         end
      end
   endtask

   // write to read-only ID with 48 pulses: overrun bits are 0, one commit only
   task automatic test_ro_overrun();
      logic [7:0]  cmds [3];
      logic [31:0] wd   [3];
      int          nb   [3];
      logic [7:0]  st;
      logic [31:0] rd;
      logic        ex;
      exp_t        e;
      cmds = '{8'h82, 8'h02, 8'h03};
      wd   = '{32'hFFFF_FFFF, 32'h0, 32'h0};
      nb   = '{48, 40, 40};
      for (int k = 0; k < 3; k++) begin
         model_frame(cmds[k], wd[k], 1'b1);
         spi_frame(cmds[k], wd[k], nb[k], 60, st, rd, ex);
         e = sb_q.pop_front();
         n_vec++;
         if (st !== e.st) begin
            n_miss++;
            $display("FAIL ro_status[%0d]: got %h expected %h", k, st, e.st);
         end
         n_vec++;
         if (rd !== e.rd) begin
            n_miss++;
            $display("FAIL ro_rdata[%0d]: got %h expected %h", k, rd, e.rd);
         end
         if (nb[k] > 40) begin
            n_vec++;
            if (ex !== 1'b0) begin
               n_miss++;
               $display("FAIL ro_overrun_miso: got %b expected 0", ex);
            end
         end
      end
   endtask

   // random commands and data with varying sck rate, frames back to back
   task automatic test_back_to_back();
      logic [7:0]  cmd;
      logic [31:0] wd;
      logic [7:0]  st;
      logic [31:0] rd;
      logic        ex;
      exp_t        e;
      for (int k = 0; k < 8; k++) begin
         cmd = 8'($urandom_range(0, 255));
         wd  = $urandom;
         model_frame(cmd, wd, 1'b1);
         spi_frame(cmd, wd, 40, int'($urandom_range(50, 90)), st, rd, ex);
         e = sb_q.pop_front();
         n_vec++;
         if (st !== e.st) begin
            n_miss++;
            $display("FAIL b2b_status[%0d] cmd %h: got %h expected %h", k, cmd, st, e.st);
         end
         n_vec++;
         if (rd !== e.rd) begin
            n_miss++;
            $display("FAIL b2b_rdata[%0d] cmd %h: got %h expected %h", k, cmd, rd, e.rd);
         end
      end
   endtask

   // reset in the middle of a write frame; registers clear and no write lands
   task automatic test_reset_midframe();
      logic [7:0]  cmds [4];
      logic [31:0] wd   [4];
      logic [39:0] bits;
      logic [7:0]  st;
      logic [31:0] rd;
      logic        ex;
      exp_t        e;
      // put known non-zero values in both scratch registers first
      model_frame(8'h81, 32'hCAFE_F00D, 1'b1);
      spi_frame(8'h81, 32'hCAFE_F00D, 40, 60, st, rd, ex);
      e = sb_q.pop_front();
      model_frame(8'h80, 32'h1234_5678, 1'b1);
      spi_frame(8'h80, 32'h1234_5678, 40, 60, st, rd, ex);
      e = sb_q.pop_front();
      bits = {8'h80, 32'hA5A5_A5A5};
      ncs  = 1'b0;
      for (int i = 0; i < 12; i++) begin
         mosi = bits[39-i];
         #60;
         sck = 1'b1;
         #60;
         sck = 1'b0;
      end
      #60;
      @(negedge clk);
      nrst = 1'b0;
      ncs  = 1'b1;
      mosi = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if (miso !== 1'b0) begin
         n_miss++;
         $display("FAIL midreset_miso: got %b expected 0", miso);
      end
      model_reset();
      @(negedge clk);
      nrst = 1'b1;
      repeat (6) @(posedge clk);
      cmds = '{8'h00, 8'h01, 8'h03, 8'h02};
      wd   = '{32'h0, 32'h0, 32'h0, 32'h0};
      for (int k = 0; k < 4; k++) begin
         model_frame(cmds[k], wd[k], 1'b1);
         spi_frame(cmds[k], wd[k], 40, 60, st, rd, ex);
         e = sb_q.pop_front();
         n_vec++;
         if (st !== e.st) begin
            n_miss++;
            $display("FAIL midreset_status[%0d]: got %h expected %h", k, st, e.st);
         end
         n_vec++;
         if (rd !== e.rd) begin
            n_miss++;
            $display("FAIL midreset_rdata[%0d]: got %h expected %h", k, rd, e.rd);
         end
      end
   endtask

   initial begin
      n_vec  = 0;
      n_miss = 0;
      test_reset();
      test_read_write_reg0();
      test_reg1_and_id();
      test_abort();
      test_ro_overrun();
      test_back_to_back();
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
